// File: rtl/adc_serial_responder.sv
`default_nettype none
// ============================================================================
// Module      : adc_serial_responder
// Description : Synthesisable model of a 4-channel serial ADC sitting at the
//               far end of an RFS/TFS frame interface. A 16-bit control word
//               arrives MSB first on din while tfs is low. A 16-bit result
//               word {sample[9:0], channel[1:0], 4'b0000} leaves MSB first on
//               dout while rfs is high. The result sent in frame k+1 belongs
//               to the channel addressed in frame k.
// Ports       : clk_clk, reset_n        - clock, synchronous active-low reset
//               enable, rfs, tfs, din   - frame enable, read/transmit frame
//                                         syncs, serial control input
//               dout                    - serial result output (combinational)
//               ch0..ch3_sample         - 10-bit unsigned "analog" inputs
//               ctrl_word               - last valid control bits [15:4]
//               cur_ch                  - channel of the loaded result
//               busy                    - conversion timer running
//               frame_done              - one-cycle pulse after frame end
//               short_frame, overrun    - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module adc_serial_responder #(
    parameter int unsigned CONV_CYCLES = 0,
    parameter int unsigned RX_BITS     = 12
) (
    input  logic       clk_clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rfs,
    input  logic       tfs,
    input  logic       din,
    output logic       dout,
    input  logic [9:0] ch0_sample,
    input  logic [9:0] ch1_sample,
    input  logic [9:0] ch2_sample,
    input  logic [9:0] ch3_sample,
    output logic [11:0] ctrl_word,
    output logic [1:0] cur_ch,
    output logic       busy,
    output logic       frame_done,
    output logic       short_frame,
    output logic       overrun
);

    localparam logic [3:0] C_RX_BITS = 4'(RX_BITS);
    localparam logic [3:0] C_CONV    = 4'(CONV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_CONVERT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tx_sr_q, tx_sr_d;
    logic [15:0] result_q, result_d;
    logic [11:0] ctrl_q, ctrl_d;
    logic [11:0] rx_sr_q, rx_sr_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [1:0]  cur_ch_q, cur_ch_d;
    logic [1:0]  pend_ch_q, pend_ch_d;
    logic [3:0]  timer_q, timer_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        short_q, short_d;
    logic        overrun_q, overrun_d;

    logic        w_rx_ok;
    logic [1:0]  w_next_ch;
    logic [1:0]  w_load_ch;
    logic [9:0]  w_sample;
    logic [15:0] w_load_word;

    // Channel select lives in word bits 10 and 9; bit 10 is inverted so the
    // controller's four command words map onto channels 0..3.
    assign w_rx_ok   = (rx_cnt_q >= C_RX_BITS);
    assign w_next_ch = w_rx_ok ? {~rx_sr_q[6], rx_sr_q[5]} : cur_ch_q;

    // A delayed load uses the channel latched at frame end; an immediate
    // load uses the channel decoded this cycle.
    assign w_load_ch = (state_q == S_CONVERT) ? pend_ch_q : w_next_ch;

    always_comb begin
        w_sample = ch0_sample;
        case (w_load_ch)
            2'd0:    w_sample = ch0_sample;
            2'd1:    w_sample = ch1_sample;
            2'd2:    w_sample = ch2_sample;
            default: w_sample = ch3_sample;
        endcase
    end

    assign w_load_word = {w_sample, w_load_ch, 4'b0000};

    always_comb begin
        state_d      = state_q;
        tx_sr_d      = tx_sr_q;
        result_d     = result_q;
        ctrl_d       = ctrl_q;
        rx_sr_d      = rx_sr_q;
        rx_cnt_d     = rx_cnt_q;
        cur_ch_d     = cur_ch_q;
        pend_ch_d    = pend_ch_q;
        timer_d      = timer_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        short_d      = short_q;
        overrun_d    = overrun_q;

        case (state_q)
            S_IDLE, S_CONVERT: begin
                if (enable) begin
                    state_d  = S_FRAME;
                    rx_cnt_d = 4'd0;
                    // New frame while converting: abandon the conversion and
                    // replay the previous result instead.
                    if (timer_q != 4'd0) begin
                        overrun_d = 1'b1;
                        busy_d    = 1'b0;
                        timer_d   = 4'd0;
                        tx_sr_d   = result_q;
                    end
                end else if (state_q == S_CONVERT) begin
                    if (timer_q <= 4'd1) begin
                        result_d = w_load_word;
                        tx_sr_d  = w_load_word;
                        cur_ch_d = w_load_ch;
                        timer_d  = 4'd0;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end

            S_FRAME: begin
                if (!enable) begin
                    frame_done_d = 1'b1;
                    if (w_rx_ok) begin
                        ctrl_d = rx_sr_q;
                    end else begin
                        short_d = 1'b1;
                    end
                    if (CONV_CYCLES == 0) begin
                        result_d = w_load_word;
                        tx_sr_d  = w_load_word;
                        cur_ch_d = w_load_ch;
                        state_d  = S_IDLE;
                    end else begin
                        pend_ch_d = w_next_ch;
                        timer_d   = C_CONV;
                        busy_d    = 1'b1;
                        state_d   = S_CONVERT;
                    end
                end else begin
                    if (rfs) begin
                        tx_sr_d = {tx_sr_q[14:0], 1'b0};
                    end
                    if (!tfs) begin
                        if (rx_cnt_q < 4'd12) begin
                            rx_sr_d = {rx_sr_q[10:0], din};
                        end
                        if (rx_cnt_q != 4'd15) begin
                            rx_cnt_d = rx_cnt_q + 4'd1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tx_sr_q      <= 16'd0;
            result_q     <= 16'd0;
            ctrl_q       <= 12'd0;
            rx_sr_q      <= 12'd0;
            rx_cnt_q     <= 4'd0;
            cur_ch_q     <= 2'd0;
            pend_ch_q    <= 2'd0;
            timer_q      <= 4'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            short_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_sr_q      <= tx_sr_d;
            result_q     <= result_d;
            ctrl_q       <= ctrl_d;
            rx_sr_q      <= rx_sr_d;
            rx_cnt_q     <= rx_cnt_d;
            cur_ch_q     <= cur_ch_d;
            pend_ch_q    <= pend_ch_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            short_q      <= short_d;
            overrun_q    <= overrun_d;
        end
    end

    // Bit 15 is presented before the first sampling edge of a frame.
    assign dout        = (enable & rfs) ? tx_sr_q[15] : 1'b0;
    assign ctrl_word   = ctrl_q;
    assign cur_ch      = cur_ch_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_serial_responder
// Description : Self-checking bench for adc_serial_responder. Two instances
//               (CONV_CYCLES = 0 and 3) share the stimulus; a scoreboard queue
//               holds the expected dout stream of each frame and a monitor
//               compares it when the frame closes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_serial_responder;

    logic       clk_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic       rfs     = 1'b0;
    logic       tfs     = 1'b1;
    logic       din     = 1'b0;
    logic [9:0] ch0_sample = 10'd0;
    logic [9:0] ch1_sample = 10'd0;
    logic [9:0] ch2_sample = 10'd0;
    logic [9:0] ch3_sample = 10'd0;

    logic        dout0, dout3;
    logic [11:0] ctrl0, ctrl3;
    logic [1:0]  cur_ch0, cur_ch3;
    logic        busy0, busy3, fd0, fd3, short0, short3, ovr0, ovr3;

    int errors = 0;
    int checks = 0;

    always #5 clk_clk = ~clk_clk;

    adc_serial_responder #(.CONV_CYCLES(0), .RX_BITS(12)) dut0 (
        .clk_clk(clk_clk), .reset_n(reset_n), .enable(enable), .rfs(rfs),
        .tfs(tfs), .din(din), .dout(dout0),
        .ch0_sample(ch0_sample), .ch1_sample(ch1_sample),
        .ch2_sample(ch2_sample), .ch3_sample(ch3_sample),
        .ctrl_word(ctrl0), .cur_ch(cur_ch0), .busy(busy0),
        .frame_done(fd0), .short_frame(short0), .overrun(ovr0)
    );

    adc_serial_responder #(.CONV_CYCLES(3), .RX_BITS(12)) dut3 (
        .clk_clk(clk_clk), .reset_n(reset_n), .enable(enable), .rfs(rfs),
        .tfs(tfs), .din(din), .dout(dout3),
        .ch0_sample(ch0_sample), .ch1_sample(ch1_sample),
        .ch2_sample(ch2_sample), .ch3_sample(ch3_sample),
        .ctrl_word(ctrl3), .cur_ch(cur_ch3), .busy(busy3),
        .frame_done(fd3), .short_frame(short3), .overrun(ovr3)
    );

    typedef struct {
        bit          chk;
        bit          sel;    // 0: dut0, 1: dut3
        int          nbits;
        logic [31:0] exp;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   frame_id = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: collects dout bits at each sampling edge and scores the frame
    // once enable falls.
    logic [31:0] cap0 = 32'd0;
    logic [31:0] cap3 = 32'd0;
    int          ncap = 0;
    bit          prev_en = 1'b0;

    always @(negedge clk_clk) begin
        exp_t        e;
        logic [31:0] got;
        logic [31:0] mask;
        if (enable && rfs) begin
            cap0 = {cap0[30:0], dout0};
            cap3 = {cap3[30:0], dout3};
            ncap++;
        end
        if (prev_en && !enable) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got=frame with no entry expected=queued entry");
            end else begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    got  = e.sel ? cap3 : cap0;
                    mask = (e.nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << e.nbits) - 32'd1);
                    checks++;
                    if ((got & mask) !== e.exp) begin
                        errors++;
                        $display("FAIL frame%0d_dout: got=0x%0h expected=0x%0h",
                                 e.id, got & mask, e.exp);
                    end
                    check($sformatf("frame%0d_bitcount", e.id), 32'(ncap), 32'(e.nbits));
                end
            end
            cap0 = 32'd0;
            cap3 = 32'd0;
            ncap = 0;
        end
        prev_en = enable;
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // One frame: a start edge, then max(n_tfs, n_rfs) data edges, then gap
    // edges with enable low (the first of which is the frame-end edge).
    task automatic frame(input logic [15:0] word, input int n_tfs, input int n_rfs,
                         input int gap, input logic [15:0] exp16, input bit do_chk,
                         input bit sel, input bit ovr_start);
        exp_t e;
        int   n;
        e.chk   = do_chk;
        e.sel   = sel;
        e.nbits = n_rfs;
        e.exp   = (n_rfs > 16) ? ({16'h0, exp16} << (n_rfs - 16)) : {16'h0, exp16};
        e.id    = frame_id;
        frame_id++;
        sb_q.push_back(e);
        n = (n_tfs > n_rfs) ? n_tfs : n_rfs;
        enable = 1'b1; rfs = 1'b0; tfs = 1'b1; din = 1'b0;
        tick();
        if (ovr_start) begin
            check("overrun_at_start", 32'(ovr3), 32'd1);
            check("busy_drop_at_start", 32'(busy3), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            rfs = (i < n_rfs);
            tfs = !(i < n_tfs);
            din = (i < 16) ? word[15 - i] : 1'b0;
            tick();
        end
        enable = 1'b0; rfs = 1'b0; tfs = 1'b1; din = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic reset_mid_frame(input logic [15:0] word);
        exp_t e;
        e.chk = 1'b0; e.sel = 1'b0; e.nbits = 0; e.exp = 32'd0; e.id = frame_id;
        frame_id++;
        sb_q.push_back(e);
        enable = 1'b1; rfs = 1'b0; tfs = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            rfs = 1'b1; tfs = 1'b0; din = word[15 - i];
            tick();
        end
        reset_n = 1'b0; enable = 1'b0; rfs = 1'b0; tfs = 1'b1; din = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk_clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Power-on reset state
        check("rst_ctrl_word", 32'(ctrl0), 32'h000);
        check("rst_cur_ch", 32'(cur_ch0), 32'd0);
        check("rst_flags", {28'd0, busy0, fd0, short0, ovr0}, 32'd0);
        check("rst_dout", 32'(dout0), 32'd0);

        // Single channel addressing: ch1 = 0x2A5 -> 0xA950 next frame
        ch1_sample = 10'h2A5;
        frame(16'h6680, 16, 16, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("t2_frame_done_hi", 32'(fd0), 32'd1);
        check("t2_ctrl_word", 32'(ctrl0), 32'h668);
        check("t2_cur_ch", 32'(cur_ch0), 32'd1);
        tick();
        check("t2_frame_done_lo", 32'(fd0), 32'd0);

        // Round robin with one-cycle gaps
        ch0_sample = 10'h001; ch1_sample = 10'h3FF;
        ch2_sample = 10'h200; ch3_sample = 10'h0AA;
        frame(16'h6480, 16, 16, 1, 16'hA950, 1'b1, 1'b0, 1'b0);
        check("rr_cur_ch0", 32'(cur_ch0), 32'd0);
        frame(16'h6680, 16, 16, 1, 16'h0040, 1'b1, 1'b0, 1'b0);
        check("rr_cur_ch1", 32'(cur_ch0), 32'd1);
        frame(16'h6080, 16, 16, 1, 16'hFFD0, 1'b1, 1'b0, 1'b0);
        check("rr_cur_ch2", 32'(cur_ch0), 32'd2);
        frame(16'h6280, 16, 16, 1, 16'h8020, 1'b1, 1'b0, 1'b0);
        check("rr_cur_ch3", 32'(cur_ch0), 32'd3);
        frame(16'h6680, 16, 16, 1, 16'h2AB0, 1'b1, 1'b0, 1'b0);
        check("rr_cur_ch_wrap", 32'(cur_ch0), 32'd1);
        check("rr_no_overrun", 32'(ovr0), 32'd0);
        check("rr_no_short", 32'(short0), 32'd0);

        // Short frame: only 8 control bits, same channel reloaded
        ch1_sample = 10'h155;
        frame(16'h6080, 8, 16, 1, 16'hFFD0, 1'b1, 1'b0, 1'b0);
        check("short_flag", 32'(short0), 32'd1);
        check("short_ctrl_held", 32'(ctrl0), 32'h668);
        check("short_cur_ch", 32'(cur_ch0), 32'd1);
        frame(16'h6480, 16, 16, 1, 16'h5550, 1'b1, 1'b0, 1'b0);
        check("short_sticky", 32'(short0), 32'd1);
        check("after_short_ctrl", 32'(ctrl0), 32'h648);

        // Overlong frame: 20 rfs edges, 16 tfs edges with nonzero low nibble
        frame(16'h628F, 16, 20, 1, 16'h0040, 1'b1, 1'b0, 1'b0);
        check("long_ctrl_12bits", 32'(ctrl0), 32'h628);
        check("long_cur_ch", 32'(cur_ch0), 32'd3);

        // Reset in the middle of a frame
        reset_mid_frame(16'h6080);
        check("midrst_ctrl_word", 32'(ctrl0), 32'h000);
        check("midrst_cur_ch", 32'(cur_ch0), 32'd0);
        check("midrst_flags", {28'd0, busy0, fd0, short0, ovr0}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        frame(16'h6680, 16, 16, 2, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("midrst_next_cur_ch", 32'(cur_ch0), 32'd1);

        // Conversion latency of 3 cycles on the second instance
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        ch0_sample = 10'h001; ch1_sample = 10'h155;
        ch2_sample = 10'h200; ch3_sample = 10'h0AA;
        frame(16'h6680, 16, 16, 1, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("conv_busy_set", 32'(busy3), 32'd1);
        check("conv_not_loaded", 32'(cur_ch3), 32'd0);
        repeat (3) tick();
        check("conv_busy_clear", 32'(busy3), 32'd0);
        check("conv_cur_ch", 32'(cur_ch3), 32'd1);
        frame(16'h6480, 16, 16, 1, 16'h5550, 1'b1, 1'b1, 1'b0);
        check("gap4_no_overrun", 32'(ovr3), 32'd0);
        check("gap1_busy", 32'(busy3), 32'd1);
        frame(16'h6080, 16, 16, 4, 16'h5550, 1'b1, 1'b1, 1'b1);
        check("ovr_sticky", 32'(ovr3), 32'd1);
        check("ovr_cur_ch", 32'(cur_ch3), 32'd2);
        frame(16'h6280, 16, 16, 4, 16'h8020, 1'b1, 1'b1, 1'b0);
        check("ovr_after_cur_ch", 32'(cur_ch3), 32'd3);

        repeat (2) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
